// File: rtl/alu_op_pkg.sv
// ALU operation encoding shared by decode, the ID/EX stage and the ALU.
// ALU_NOP is the all-zero code so that a cleared register reads as a bubble.
package alu_op_pkg;

    localparam int unsigned AluOpW = 5;

    typedef logic [AluOpW-1:0] alu_op_t;

    localparam alu_op_t ALU_NOP  = 5'd0;
    localparam alu_op_t ALU_ADD  = 5'd1;
    localparam alu_op_t ALU_SUB  = 5'd2;
    localparam alu_op_t ALU_AND  = 5'd3;
    localparam alu_op_t ALU_OR   = 5'd4;
    localparam alu_op_t ALU_XOR  = 5'd5;
    localparam alu_op_t ALU_SLL  = 5'd6;
    localparam alu_op_t ALU_SRL  = 5'd7;
    localparam alu_op_t ALU_SRA  = 5'd8;
    localparam alu_op_t ALU_SLT  = 5'd9;
    localparam alu_op_t ALU_SLTU = 5'd10;
    localparam alu_op_t ALU_LUI  = 5'd11;

endpackage

// File: rtl/pipe_pkg.sv
// Pipeline-wide types: the forwarding-source selector reported by the
// operand forwarding muxes.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Combinational operand forwarding mux.
// Picks the freshest value of source register rs_i with priority
// EX > MEM > WB > register file. Register x0 always reads as zero.
// Ports:
//   rs_i                       source register index
//   rf_data_i                  register-file value of rs_i
//   ex_we_i/ex_rd_i/ex_data_i  result of the instruction currently in EX
//   mem_we_i/mem_rd_i/mem_data_i  writeback candidate in MEM
//   wb_we_i/wb_rd_i/wb_data_i  writeback value in WB
//   data_o                     selected operand
//   sel_o                      which source was selected
module operand_fwd_mux
    import pipe_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic [RADDR-1:0] rs_i,
    input  logic [N-1:0]     rf_data_i,
    input  logic             ex_we_i,
    input  logic [RADDR-1:0] ex_rd_i,
    input  logic [N-1:0]     ex_data_i,
    input  logic             mem_we_i,
    input  logic [RADDR-1:0] mem_rd_i,
    input  logic [N-1:0]     mem_data_i,
    input  logic             wb_we_i,
    input  logic [RADDR-1:0] wb_rd_i,
    input  logic [N-1:0]     wb_data_i,
    output logic [N-1:0]     data_o,
    output fwd_sel_t         sel_o
);

    always_comb begin
        sel_o  = FWD_RF;
        data_o = rf_data_i;
        if (rs_i == '0) begin
            // x0 is hard-wired: ignore any source that claims to write it
            sel_o  = FWD_RF;
            data_o = '0;
        end else if (ex_we_i && (ex_rd_i == rs_i)) begin
            sel_o  = FWD_EX;
            data_o = ex_data_i;
        end else if (mem_we_i && (mem_rd_i == rs_i)) begin
            sel_o  = FWD_MEM;
            data_o = mem_data_i;
        end else if (wb_we_i && (wb_rd_i == rs_i)) begin
            sel_o  = FWD_WB;
            data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the execute ALU.
// Captures a decoded instruction with both operands already resolved by
// forwarding from EX, MEM and WB, inserts a bubble on load-use hazards, and
// supports flush and downstream back-pressure.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          decode handshake
//   rs1_addr/rs2_addr/rd_addr  register indices of the offered instruction
//   rs1_rdata/rs2_rdata/imm    register-file values and immediate
//   use_imm                    operand 2 comes from imm
//   alu_op_in, reg_write_in, mem_read_in  decoded control
//   ex_result                  ALU result of the held instruction
//   mem_rd/mem_we/mem_data     MEM-stage writeback candidate
//   wb_rd/wb_we/wb_data        WB-stage writeback value
//   flush                      kill held and offered instructions
//   out_ready/out_valid        downstream handshake
//   data_1/data_2/alu_op       registered ALU inputs
//   rd_out/reg_write_out/mem_read_out  registered control
module id_ex_operand_stage
    import alu_op_pkg::*;
    import pipe_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RADDR-1:0] rs1_addr,
    input  logic [RADDR-1:0] rs2_addr,
    input  logic [RADDR-1:0] rd_addr,
    input  logic [N-1:0]     rs1_rdata,
    input  logic [N-1:0]     rs2_rdata,
    input  logic [N-1:0]     imm,
    input  logic             use_imm,
    input  logic [4:0]       alu_op_in,
    input  logic             reg_write_in,
    input  logic             mem_read_in,
    input  logic [N-1:0]     ex_result,
    input  logic [RADDR-1:0] mem_rd,
    input  logic             mem_we,
    input  logic [N-1:0]     mem_data,
    input  logic [RADDR-1:0] wb_rd,
    input  logic             wb_we,
    input  logic [N-1:0]     wb_data,
    input  logic             flush,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [N-1:0]     data_1,
    output logic [N-1:0]     data_2,
    output logic [4:0]       alu_op,
    output logic [RADDR-1:0] rd_out,
    output logic             reg_write_out,
    output logic             mem_read_out
);

    logic             out_valid_q, out_valid_d;
    logic [N-1:0]     data_1_q, data_1_d;
    logic [N-1:0]     data_2_q, data_2_d;
    logic [4:0]       alu_op_q, alu_op_d;
    logic [RADDR-1:0] rd_q, rd_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q, mem_read_d;

    logic             load_use;
    logic             hold;
    logic             accept;
    logic             ex_fwd_we;
    logic [N-1:0]     fwd1_data, fwd2_data;
    fwd_sel_t         fwd1_sel, fwd2_sel;

    // A load's data is not available in EX; only non-load writers forward from here.
    assign ex_fwd_we = out_valid_q && reg_write_q && !mem_read_q;

    // Operand 2 only conflicts with a load when it is actually read from rs2.
    assign load_use = out_valid_q && mem_read_q && reg_write_q && (rd_q != '0) &&
                      ((rd_q == rs1_addr) || (!use_imm && (rd_q == rs2_addr)));

    assign hold     = out_valid_q && !out_ready;
    assign in_ready = (!out_valid_q || out_ready) && !load_use && !flush;
    assign accept   = in_valid && in_ready;

    operand_fwd_mux #(
        .N     (N),
        .RADDR (RADDR)
    ) u_fwd_rs1 (
        .rs_i       (rs1_addr),
        .rf_data_i  (rs1_rdata),
        .ex_we_i    (ex_fwd_we),
        .ex_rd_i    (rd_q),
        .ex_data_i  (ex_result),
        .mem_we_i   (mem_we),
        .mem_rd_i   (mem_rd),
        .mem_data_i (mem_data),
        .wb_we_i    (wb_we),
        .wb_rd_i    (wb_rd),
        .wb_data_i  (wb_data),
        .data_o     (fwd1_data),
        .sel_o      (fwd1_sel)
    );

    operand_fwd_mux #(
        .N     (N),
        .RADDR (RADDR)
    ) u_fwd_rs2 (
        .rs_i       (rs2_addr),
        .rf_data_i  (rs2_rdata),
        .ex_we_i    (ex_fwd_we),
        .ex_rd_i    (rd_q),
        .ex_data_i  (ex_result),
        .mem_we_i   (mem_we),
        .mem_rd_i   (mem_rd),
        .mem_data_i (mem_data),
        .wb_we_i    (wb_we),
        .wb_rd_i    (wb_rd),
        .wb_data_i  (wb_data),
        .data_o     (fwd2_data),
        .sel_o      (fwd2_sel)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        data_1_d    = data_1_q;
        data_2_d    = data_2_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;

        if (flush) begin
            out_valid_d = 1'b0;
            alu_op_d    = ALU_NOP;
            rd_d        = '0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else if (hold) begin
            // keep everything
        end else if (accept) begin
            out_valid_d = 1'b1;
            data_1_d    = fwd1_data;
            data_2_d    = use_imm ? imm : fwd2_data;
            alu_op_d    = alu_op_in;
            rd_d        = rd_addr;
            reg_write_d = reg_write_in;
            mem_read_d  = mem_read_in;
        end else begin
            // Bubble (idle decode or load-use stall); data regs keep stale values.
            out_valid_d = 1'b0;
            alu_op_d    = ALU_NOP;
            rd_d        = '0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            data_1_q    <= '0;
            data_2_q    <= '0;
            alu_op_q    <= ALU_NOP;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            data_1_q    <= data_1_d;
            data_2_q    <= data_2_d;
            alu_op_q    <= alu_op_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign data_1        = data_1_q;
    assign data_2        = data_2_q;
    assign alu_op        = alu_op_q;
    assign rd_out        = rd_q;
    assign reg_write_out = reg_write_q;
    assign mem_read_out  = mem_read_q;

    // x0 never takes a forwarded value.
    a_rs1_zero_rf : assert property (@(posedge clk) disable iff (!rst_n)
        (rs1_addr == '0) |-> (fwd1_sel == FWD_RF));
    a_rs2_zero_rf : assert property (@(posedge clk) disable iff (!rst_n)
        (rs2_addr == '0) |-> (fwd2_sel == FWD_RF));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

    localparam logic [4:0] NOP = 5'd0;
    localparam logic [4:0] ADD = 5'd1;
    localparam logic [4:0] SUB = 5'd2;
    localparam logic [4:0] AND = 5'd3;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1_rdata, rs2_rdata, imm;
    logic        use_imm;
    logic [4:0]  alu_op_in;
    logic        reg_write_in, mem_read_in;
    logic [31:0] ex_result;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_we, wb_we;
    logic [31:0] mem_data, wb_data;
    logic        flush, out_ready, out_valid;
    logic [31:0] data_1, data_2;
    logic [4:0]  alu_op, rd_out;
    logic        reg_write_out, mem_read_out;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: what the stage should currently hold.
    logic        m_valid;
    logic [31:0] m_d1, m_d2;
    logic [4:0]  m_op, m_rd;
    logic        m_rw, m_mr;

    id_ex_operand_stage #(.N(32), .RADDR(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rd_addr       (rd_addr),
        .rs1_rdata     (rs1_rdata),
        .rs2_rdata     (rs2_rdata),
        .imm           (imm),
        .use_imm       (use_imm),
        .alu_op_in     (alu_op_in),
        .reg_write_in  (reg_write_in),
        .mem_read_in   (mem_read_in),
        .ex_result     (ex_result),
        .mem_rd        (mem_rd),
        .mem_we        (mem_we),
        .mem_data      (mem_data),
        .wb_rd         (wb_rd),
        .wb_we         (wb_we),
        .wb_data       (wb_data),
        .flush         (flush),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .data_1        (data_1),
        .data_2        (data_2),
        .alu_op        (alu_op),
        .rd_out        (rd_out),
        .reg_write_out (reg_write_out),
        .mem_read_out  (mem_read_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return 32'd0;
        if (m_valid && m_rw && !m_mr && m_rd == rs) return ex_result;
        if (mem_we && mem_rd == rs) return mem_data;
        if (wb_we && wb_rd == rs) return wb_data;
        return rf;
    endfunction

    function automatic logic ref_ready();
        logic stall;
        stall = m_valid && m_mr && m_rw && m_rd != 5'd0 &&
                (m_rd == rs1_addr || (!use_imm && m_rd == rs2_addr));
        return (!m_valid || out_ready) && !stall && !flush;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_d1 = '0; m_d2 = '0; m_op = NOP; m_rd = '0; m_rw = 1'b0; m_mr = 1'b0;
    endtask

    // Advance one clock; the model computes its next state from pre-edge inputs.
    task automatic tick();
        logic        nv, nrw, nmr;
        logic [31:0] n1, n2;
        logic [4:0]  nop, nrd;
        nv = m_valid; n1 = m_d1; n2 = m_d2; nop = m_op; nrd = m_rd; nrw = m_rw; nmr = m_mr;
        if (flush) begin
            nv = 0; nop = NOP; nrw = 0; nmr = 0;
        end else if (m_valid && !out_ready) begin
            nv = m_valid;
        end else if (in_valid && ref_ready()) begin
            nv = 1; nop = alu_op_in; nrd = rd_addr; nrw = reg_write_in; nmr = mem_read_in;
            n1 = ref_operand(rs1_addr, rs1_rdata);
            n2 = use_imm ? imm : ref_operand(rs2_addr, rs2_rdata);
        end else begin
            nv = 0; nop = NOP; nrw = 0; nmr = 0;
        end
        @(posedge clk);
        m_valid = nv; m_d1 = n1; m_d2 = n2; m_op = nop; m_rd = nrd; m_rw = nrw; m_mr = nmr;
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; rs1_addr = 0; rs2_addr = 0; rd_addr = 0; rs1_rdata = 0; rs2_rdata = 0;
        imm = 0; use_imm = 0; alu_op_in = NOP; reg_write_in = 0; mem_read_in = 0;
        ex_result = 0; mem_rd = 0; mem_we = 0; mem_data = 0; wb_rd = 0; wb_we = 0;
        wb_data = 0; flush = 0; out_ready = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        n_cmp++; if (alu_op !== NOP) begin n_fail++;
            $display("FAIL reset_alu_op got=%0d want=%0d", alu_op, NOP); end
        n_cmp++; if (data_1 !== 32'd0 || data_2 !== 32'd0) begin n_fail++;
            $display("FAIL reset_data got=%h/%h want=0/0", data_1, data_2); end
        n_cmp++; if (rd_out !== 5'd0 || reg_write_out !== 1'b0 || mem_read_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%0d/%0b/%0b want=0/0/0", rd_out, reg_write_out,
                     mem_read_out); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        // add x3, x1, x2 with x1=5, x2=7
        in_valid = 1; rs1_addr = 1; rs2_addr = 2; rd_addr = 3; rs1_rdata = 5; rs2_rdata = 7;
        alu_op_in = ADD; reg_write_in = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL add_in_ready got=%0b want=1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || alu_op !== ADD) begin n_fail++;
            $display("FAIL add_ctrl got=%0b/%0d want=1/%0d", out_valid, alu_op, ADD); end
        n_cmp++; if (data_1 !== 32'd5 || data_2 !== 32'd7 || rd_out !== 5'd3) begin n_fail++;
            $display("FAIL add_data got=%0d/%0d rd=%0d want=5/7 rd=3", data_1, data_2, rd_out);
        end
    endtask

    task automatic test_ex_forward();
        // held x3 produces 12; sub x8, x3, x0 must see 12, and x0 must read 0
        ex_result = 32'd12;
        rs1_addr = 3; rs2_addr = 0; rd_addr = 8; rs1_rdata = 99; rs2_rdata = 55; alu_op_in = SUB;
        tick();
        n_cmp++; if (data_1 !== 32'd12) begin n_fail++;
            $display("FAIL ex_fwd got=%0d want=12", data_1); end
        n_cmp++; if (data_2 !== 32'd0 || alu_op !== SUB) begin n_fail++;
            $display("FAIL ex_fwd_x0 got=%0d op=%0d want=0 op=%0d", data_2, alu_op, SUB); end
    endtask

    task automatic test_priority();
        rs1_addr = 4; rs2_addr = 4; rd_addr = 9; rs1_rdata = 32'h77; rs2_rdata = 32'h77;
        alu_op_in = AND; mem_we = 1; mem_rd = 4; mem_data = 32'hA; wb_we = 1; wb_rd = 4;
        wb_data = 32'hB;
        tick();
        n_cmp++; if (data_1 !== 32'hA || data_2 !== 32'hA) begin n_fail++;
            $display("FAIL mem_over_wb got=%h/%h want=a/a", data_1, data_2); end
        // WB claims x0 with 0xFF: x0 still 0; rs2=x6 unclaimed -> rf value
        rs1_addr = 0; rs2_addr = 6; rd_addr = 10; rs1_rdata = 32'h11; rs2_rdata = 32'h33;
        mem_we = 0; wb_rd = 0; wb_data = 32'hFF;
        tick();
        n_cmp++; if (data_1 !== 32'd0 || data_2 !== 32'h33) begin n_fail++;
            $display("FAIL x0_wb got=%h/%h want=0/33", data_1, data_2); end
        // WB-only hit on rs1, operand 2 from immediate
        rs1_addr = 6; rd_addr = 11; wb_rd = 6; wb_data = 32'hB6; use_imm = 1; imm = 32'hFFFF_FFF0;
        tick();
        n_cmp++; if (data_1 !== 32'hB6 || data_2 !== 32'hFFFF_FFF0) begin n_fail++;
            $display("FAIL wb_imm got=%h/%h want=b6/fffffff0", data_1, data_2); end
        wb_we = 0; use_imm = 0; imm = 0;
    endtask

    task automatic test_load_use();
        // lw x6, 4(x1)
        rs1_addr = 1; rs2_addr = 0; rd_addr = 6; rs1_rdata = 32'h100; use_imm = 1; imm = 4;
        mem_read_in = 1; reg_write_in = 1; alu_op_in = ADD;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || mem_read_out !== 1'b1) begin n_fail++;
            $display("FAIL lw_held got=%0b/%0b want=1/1", out_valid, mem_read_out); end
        // add x7, x6, x2
        rs1_addr = 6; rs2_addr = 2; rd_addr = 7; rs1_rdata = 32'hDEAD; rs2_rdata = 32'd2;
        use_imm = 0; imm = 0; mem_read_in = 0;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++;
            $display("FAIL lu_stall got=%0b want=0", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || alu_op !== NOP || reg_write_out !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_bubble got=%0b/%0d/%0b want=0/0/0", out_valid, alu_op,
                     reg_write_out); end
        mem_we = 1; mem_rd = 6; mem_data = 32'h42;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL lu_release got=%0b want=1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || data_1 !== 32'h42 || data_2 !== 32'd2 ||
                     alu_op !== ADD || rd_out !== 5'd7) begin n_fail++;
            $display("FAIL lu_accept got=%0b %h/%h op=%0d rd=%0d want=1 42/2 op=1 rd=7",
                     out_valid, data_1, data_2, alu_op, rd_out); end
        mem_we = 0;
    endtask

    task automatic test_backpressure_flush();
        out_ready = 0;
        rs1_addr = 1; rs2_addr = 2; rd_addr = 12; rs1_rdata = 32'h5A; rs2_rdata = 32'hA5;
        alu_op_in = SUB;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++;
                $display("FAIL bp_in_ready cycle=%0d got=%0b want=0", i, in_ready); end
            tick();
            n_cmp++; if (out_valid !== 1'b1 || data_1 !== 32'h42 || data_2 !== 32'd2 ||
                         alu_op !== ADD || rd_out !== 5'd7) begin n_fail++;
                $display("FAIL bp_hold cycle=%0d got=%0b %h/%h op=%0d rd=%0d want=1 42/2 op=1 rd=7",
                         i, out_valid, data_1, data_2, alu_op, rd_out); end
        end
        flush = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++;
            $display("FAIL flush_in_ready got=%0b want=0", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || alu_op !== NOP || reg_write_out !== 1'b0) begin
            n_fail++;
            $display("FAIL flush got=%0b/%0d/%0b want=0/0/0", out_valid, alu_op, reg_write_out);
        end
        flush = 0; out_ready = 1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            rs1_addr     = 5'($urandom_range(0, 7));
            rs2_addr     = 5'($urandom_range(0, 7));
            rd_addr      = 5'($urandom_range(0, 7));
            rs1_rdata    = $urandom;
            rs2_rdata    = $urandom;
            imm          = $urandom;
            use_imm      = ($urandom_range(0, 3) == 0);
            alu_op_in    = 5'($urandom_range(1, 11));
            reg_write_in = ($urandom_range(0, 3) != 0);
            mem_read_in  = ($urandom_range(0, 3) == 0);
            ex_result    = $urandom;
            mem_rd       = 5'($urandom_range(0, 7));
            mem_we       = ($urandom_range(0, 1) == 1);
            mem_data     = $urandom;
            wb_rd        = 5'($urandom_range(0, 7));
            wb_we        = ($urandom_range(0, 1) == 1);
            wb_data      = $urandom;
            flush        = ($urandom_range(0, 15) == 0);
            out_ready    = ($urandom_range(0, 3) != 0);
            #1;
            n_cmp++; if (in_ready !== ref_ready()) begin n_fail++;
                $display("FAIL rnd_in_ready it=%0d got=%0b want=%0b", i, in_ready, ref_ready());
            end
            tick();
            n_cmp++; if (out_valid !== m_valid || alu_op !== m_op || reg_write_out !== m_rw ||
                         mem_read_out !== m_mr) begin n_fail++;
                $display("FAIL rnd_ctrl it=%0d got=%0b/%0d/%0b/%0b want=%0b/%0d/%0b/%0b", i,
                         out_valid, alu_op, reg_write_out, mem_read_out, m_valid, m_op, m_rw,
                         m_mr); end
            if (m_valid) begin
                n_cmp++; if (data_1 !== m_d1 || data_2 !== m_d2 || rd_out !== m_rd) begin
                    n_fail++;
                    $display("FAIL rnd_data it=%0d got=%h/%h rd=%0d want=%h/%h rd=%0d", i,
                             data_1, data_2, rd_out, m_d1, m_d2, m_rd); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        in_valid = 1; rs1_addr = 0; rs2_addr = 0; rd_addr = 5; alu_op_in = ADD;
        reg_write_in = 1; imm = 32'h99; use_imm = 1;
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++;
            $display("FAIL arst_pre got=%0b want=1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || alu_op !== NOP || data_2 !== 32'd0 ||
                     reg_write_out !== 1'b0) begin n_fail++;
            $display("FAIL arst got=%0b/%0d/%h/%0b want=0/0/0/0", out_valid, alu_op, data_2,
                     reg_write_out); end
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_ex_forward();
        test_priority();
        test_load_use();
        test_backpressure_flush();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
